// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline flow controller and its perf counters.
package pipe_pkg;
    localparam int CNT_W  = 3;
    localparam int PERF_W = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;
endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// Hazard requests in, stage enables / strobes / valids / perf counts out.
interface pipe_flow_ctrl_if;
    import pipe_pkg::*;

    logic              pc_sel;
    logic              ld_use;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              stall;
    logic              v_id;
    logic              v_ex;
    logic              v_mem;
    logic              v_wb;
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_flush_cnt;

    modport master (
        input  pc_sel, ld_use,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, stall,
               v_id, v_ex, v_mem, v_wb, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        output pc_sel, ld_use,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, stall,
               v_id, v_ex, v_mem, v_wb, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/pipe_flow_perf.sv
// Load-use bubble and redirect event counters; 1-cycle latency, wrap at 2^PERF_W.
// No backpressure: one event per cycle per counter is always accepted.
module pipe_flow_perf
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              lu_evt,
    input  logic              br_evt,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + PERF_W'(lu_evt);
        flush_cnt_d = flush_cnt_q + PERF_W'(br_evt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: rtl/pipe_flow_ctrl.sv
// Five-stage pipeline flow controller: enables/strobes combinational, valids 1 cycle.
// ld_use holds PC and IF/ID for LU_CYCLES; redirects squash IF/ID for FLUSH_CYCLES; PIPE_FLOW_PERF_EN adds counters.
module pipe_flow_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int LU_CYCLES    = 1
) (
    input  logic             clk,
    input  logic             rst,
    pipe_flow_ctrl_if.master pif
);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LU_RELOAD    = CNT_W'(LU_CYCLES - 1);
    localparam logic             FLUSH_MULTI  = (FLUSH_CYCLES > 1);
    localparam logic             LU_MULTI     = (LU_CYCLES > 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             v_id_q, v_id_d;
    logic             v_ex_q, v_ex_d;
    logic             v_mem_q, v_mem_d;
    logic             v_wb_q, v_wb_d;

    logic br_qual, lu_qual;
    logic pc_en, if_id_en, if_id_flush, id_ex_bubble;

    assign lu_qual = pif.ld_use & v_id_q & v_ex_q & ~pif.pc_sel;
    assign br_qual = pif.pc_sel & v_ex_q;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (br_qual) begin
            // Redirect wins in every state and restarts the squash window.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
            cnt_d        = FLUSH_MULTI ? FLUSH_RELOAD : '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lu_qual) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = LU_MULTI ? ST_LU_STALL : ST_RUN;
                        cnt_d        = LU_MULTI ? LU_RELOAD : '0;
                    end
                end
                ST_LU_STALL: begin
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end

        // Reset loads NOPs into every stage register.
        if (rst) begin
            pc_en        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end

        v_id_d  = if_id_flush ? 1'b0 : (if_id_en ? 1'b1 : v_id_q);
        v_ex_d  = v_id_q & ~id_ex_bubble;
        v_mem_d = v_ex_q;
        v_wb_d  = v_mem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            v_id_q  <= 1'b0;
            v_ex_q  <= 1'b0;
            v_mem_q <= 1'b0;
            v_wb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_id_q  <= v_id_d;
            v_ex_q  <= v_ex_d;
            v_mem_q <= v_mem_d;
            v_wb_q  <= v_wb_d;
        end
    end

    assign pif.pc_en        = pc_en;
    assign pif.if_id_en     = if_id_en;
    assign pif.if_id_flush  = if_id_flush;
    assign pif.id_ex_bubble = id_ex_bubble;
    assign pif.stall        = rst | lu_qual | br_qual | (state_q != ST_RUN);
    assign pif.v_id         = v_id_q;
    assign pif.v_ex         = v_ex_q;
    assign pif.v_mem        = v_mem_q;
    assign pif.v_wb         = v_wb_q;

`ifdef PIPE_FLOW_PERF_EN
    logic              lu_evt, br_evt;
    logic [PERF_W-1:0] stall_cnt, flush_cnt;

    // Only bubbles caused by load-use count; redirect bubbles are excluded.
    assign lu_evt = ~rst & ~br_qual &
                    (((state_q == ST_RUN) & lu_qual) | (state_q == ST_LU_STALL));
    assign br_evt = ~rst & br_qual;

    pipe_flow_perf u_perf (
        .clk       (clk),
        .rst       (rst),
        .lu_evt    (lu_evt),
        .br_evt    (br_evt),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    assign pif.perf_stall_cnt = stall_cnt;
    assign pif.perf_flush_cnt = flush_cnt;
`else
    assign pif.perf_stall_cnt = '0;
    assign pif.perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Two configurations driven by the same stimulus, each scored against a cycle-count model.
module tb_pipe_flow_ctrl;
    typedef struct packed {
        logic [4:0]  strb;   // pc_en, if_id_en, if_id_flush, id_ex_bubble, stall
        logic [3:0]  v;      // v_wb, v_mem, v_ex, v_id
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    localparam int FL_A = 1, LU_A = 1;
    localparam int FL_B = 2, LU_B = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pc_sel = 1'b0;
    logic ld_use = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_flow_ctrl_if ifa ();
    pipe_flow_ctrl_if ifb ();

    assign ifa.pc_sel = pc_sel;
    assign ifa.ld_use = ld_use;
    assign ifb.pc_sel = pc_sel;
    assign ifb.ld_use = ld_use;

    pipe_flow_ctrl #(.FLUSH_CYCLES(FL_A), .LU_CYCLES(LU_A)) dut_a (.clk(clk), .rst(rst), .pif(ifa));
    pipe_flow_ctrl #(.FLUSH_CYCLES(FL_B), .LU_CYCLES(LU_B)) dut_b (.clk(clk), .rst(rst), .pif(ifb));

    exp_t act0, act1;
    assign act0 = {ifa.pc_en, ifa.if_id_en, ifa.if_id_flush, ifa.id_ex_bubble, ifa.stall,
                   ifa.v_wb, ifa.v_mem, ifa.v_ex, ifa.v_id, ifa.perf_stall_cnt, ifa.perf_flush_cnt};
    assign act1 = {ifb.pc_en, ifb.if_id_en, ifb.if_id_flush, ifb.id_ex_bubble, ifb.stall,
                   ifb.v_wb, ifb.v_mem, ifb.v_ex, ifb.v_id, ifb.perf_stall_cnt, ifb.perf_flush_cnt};

    exp_t q0[$];
    exp_t q1[$];

    // Model state: remaining flush / load-use cycles after the current one, the
    // valid pipeline as a shift vector, and the event totals.
    int          fl_left[2] = '{0, 0};
    int          lu_left[2] = '{0, 0};
    logic [3:0]  mv[2]      = '{4'b0, 4'b0};
    logic [31:0] msc[2]     = '{32'd0, 32'd0};
    logic [31:0] mfc[2]     = '{32'd0, 32'd0};

    task automatic model_step(input int k, input logic r, input logic ps, input logic lu);
        exp_t e;
        int   nfl, nlu;
        logic br, lq, pe, ie, fl, bu, st, vid_n;
        nfl = (k == 0) ? FL_A : FL_B;
        nlu = (k == 0) ? LU_A : LU_B;
        br  = ps && mv[k][1];
        lq  = lu && mv[k][0] && mv[k][1] && !ps;
        pe = 1'b1; ie = 1'b1; fl = 1'b0; bu = 1'b0;
        if (r || br || fl_left[k] > 0) begin
            fl = 1'b1; bu = 1'b1;
        end else if (lu_left[k] > 0 || lq) begin
            pe = 1'b0; ie = 1'b0; bu = 1'b1;
        end
        st = r || br || lq || fl_left[k] > 0 || lu_left[k] > 0;
        e.strb = {pe, ie, fl, bu, st};
        e.v    = mv[k];
`ifdef PIPE_FLOW_PERF_EN
        e.sc = msc[k];
        e.fc = mfc[k];
`else
        e.sc = 32'd0;
        e.fc = 32'd0;
`endif
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);

        if (r) begin
            mv[k] = 4'b0; fl_left[k] = 0; lu_left[k] = 0; msc[k] = 32'd0; mfc[k] = 32'd0;
        end else begin
            vid_n = fl ? 1'b0 : (ie ? 1'b1 : mv[k][0]);
            mv[k] = {mv[k][2], mv[k][1], mv[k][0] & !bu, vid_n};
            if (br) begin
                fl_left[k] = nfl - 1; lu_left[k] = 0; mfc[k] = mfc[k] + 32'd1;
            end else if (fl_left[k] > 0) begin
                fl_left[k] = fl_left[k] - 1;
            end else if (lu_left[k] > 0) begin
                lu_left[k] = lu_left[k] - 1; msc[k] = msc[k] + 32'd1;
            end else if (lq) begin
                lu_left[k] = nlu - 1; msc[k] = msc[k] + 32'd1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic ps, input logic lu);
        @(posedge clk);
        #1;
        rst = r; pc_sel = ps; ld_use = lu;
        model_step(0, r, ps, lu);
        model_step(1, r, ps, lu);
    endtask

    task automatic check(input int k, input exp_t e, input exp_t a);
        n_tests++;
        if (a.strb !== e.strb) begin
            n_fail++;
            $display("FAIL inst%0d strobes got %b want %b at %0t", k, a.strb, e.strb, $time);
        end
        n_tests++;
        if (a.v !== e.v) begin
            n_fail++;
            $display("FAIL inst%0d valids got %b want %b at %0t", k, a.v, e.v, $time);
        end
        n_tests++;
        if (a.sc !== e.sc) begin
            n_fail++;
            $display("FAIL inst%0d perf_stall got %0d want %0d at %0t", k, a.sc, e.sc, $time);
        end
        n_tests++;
        if (a.fc !== e.fc) begin
            n_fail++;
            $display("FAIL inst%0d perf_flush got %0d want %0d at %0t", k, a.fc, e.fc, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check(0, e, act0);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check(1, e, act1);
        end
    end

    initial begin
        logic r, ps, lu;
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) < 2);
            ps = ($urandom_range(0, 99) < 18);
            lu = ($urandom_range(0, 99) < 40);
            cyc(r, ps, lu);
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (q0.size() + q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q0.size() + q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
